// File: rtl/cpu_pkg.sv
// Shared CPU constants and the memory responder state encoding.
// Data/address widths here match the control unit's MEM_STAGE view.
package cpu_pkg;
  localparam int CPU_DATA_W = 16;
  localparam int CPU_ADDR_W = 8;

  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, ACK} mem_state_t;
endpackage

// File: rtl/mem_array.sv
// Single-port synchronous RAM with registered read data.
// MEM_PARITY_EN adds a stored even-parity bit per word, checked on read.
module mem_array #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en_i,
  input  logic              we_i,
  input  logic              clr_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              perr_o
);
`ifdef MEM_PARITY_EN
  localparam int WW = DATA_W + 1;
`else
  localparam int WW = DATA_W;
`endif

  logic [WW-1:0]     mem_q [DEPTH];
  logic [WW-1:0]     wword;
  logic [DATA_W-1:0] rdata_q;
  logic              perr_q;

`ifdef MEM_PARITY_EN
  assign wword = {^wdata_i, wdata_i};
`else
  assign wword = wdata_i;
`endif

  // Storage is deliberately not reset; contents survive rst_n.
  always_ff @(posedge clk)
    if (en_i && we_i && !clr_i) mem_q[addr_i] <= wword;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rdata_q <= '0;
      perr_q  <= 1'b0;
    end else if (en_i) begin
      if (clr_i) begin
        rdata_q <= '0;
        perr_q  <= 1'b0;
      end else if (!we_i) begin
        rdata_q <= mem_q[addr_i][DATA_W-1:0];
`ifdef MEM_PARITY_EN
        perr_q  <= ^mem_q[addr_i];
`else
        perr_q  <= 1'b0;
`endif
      end else begin
        perr_q  <= 1'b0;
      end
    end

  assign rdata_o = rdata_q;
  assign perr_o  = perr_q;
endmodule

// File: rtl/mem_responder.sv
// MEM_STAGE memory responder: latch request, wait, access, four-phase ack.
// Optional MEM_PARITY_EN (in mem_array) reports stored-parity errors on err.
module mem_responder
  import cpu_pkg::*;
#(
  parameter int DATA_W      = CPU_DATA_W,
  parameter int ADDR_W      = CPU_ADDR_W,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              read,
  input  logic              write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ack,
  output logic              busy,
  output logic              err
);
  localparam logic [3:0]      WAIT_INIT = 4'(WAIT_CYCLES);
  localparam logic [ADDR_W:0] DEPTH_L   = (ADDR_W+1)'(DEPTH);

  mem_state_t        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              wr_q, wr_d, bad_q, bad_d;
  logic              ack_q, ack_d, busy_q, busy_d, err_q, err_d;
  logic              req, arr_en, perr;

  assign req = read | write;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req) state_d = (WAIT_CYCLES == 0) ? ACCESS : WAIT;
      WAIT:    if (cnt_q <= 4'd1) state_d = ACCESS;
      ACCESS:  state_d = ACK;
      ACK:     if (!req) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Error causes are decided at accept so late input changes cannot matter.
  always_comb begin
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    bad_d   = bad_q;
    ack_d   = ack_q;
    busy_d  = busy_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (req) begin
        addr_d  = addr;
        wdata_d = wdata;
        wr_d    = write;
        bad_d   = (read & write) | ({1'b0, addr} >= DEPTH_L);
        cnt_d   = WAIT_INIT;
        busy_d  = 1'b1;
      end
      WAIT:   cnt_d = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
      ACCESS: begin
        ack_d  = 1'b1;
        busy_d = 1'b0;
        err_d  = bad_q;
      end
      ACK: if (!req) begin
        ack_d = 1'b0;
        err_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      bad_q   <= 1'b0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      bad_q   <= bad_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end

  assign arr_en = (state_q == ACCESS);

  mem_array #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_arr (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_i    (arr_en),
    .we_i    (wr_q),
    .clr_i   (bad_q),
    .addr_i  (addr_q),
    .wdata_i (wdata_q),
    .rdata_o (rdata),
    .perr_o  (perr)
  );

  // Parity flag lingers in the array; only expose it while acknowledging.
  assign ack  = ack_q;
  assign busy = busy_q;
  assign err  = err_q | (ack_q & perr);
endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: dut 0 (DEPTH 256, 2 waits), dut 1 (DEPTH 200, 0 waits).
// Parity corruption check runs only when MEM_PARITY_EN is defined.
module tb_mem_responder;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        rd_v [2];
  logic        wr_v [2];
  logic [7:0]  ad_v [2];
  logic [15:0] wd_v [2];
  logic [15:0] rdata_v [2];
  logic        ack_v [2];
  logic        busy_v [2];
  logic        err_v [2];
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  mem_responder #(.DATA_W(16), .ADDR_W(8), .DEPTH(256), .WAIT_CYCLES(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .read(rd_v[0]), .write(wr_v[0]), .addr(ad_v[0]),
    .wdata(wd_v[0]), .rdata(rdata_v[0]), .ack(ack_v[0]), .busy(busy_v[0]), .err(err_v[0]));

  mem_responder #(.DATA_W(16), .ADDR_W(8), .DEPTH(200), .WAIT_CYCLES(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .read(rd_v[1]), .write(wr_v[1]), .addr(ad_v[1]),
    .wdata(wd_v[1]), .rdata(rdata_v[1]), .ack(ack_v[1]), .busy(busy_v[1]), .err(err_v[1]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Raise a request, count edges to ack, check result, hold, then drop.
  task automatic txn(input int s, input logic r, input logic w, input logic [7:0] a,
                     input logic [15:0] d, input int lat, input logic e,
                     input logic [15:0] exp_rd, input int hold);
    int n;
    n = 0;
    rd_v[s] = r; wr_v[s] = w; ad_v[s] = a; wd_v[s] = d;
    do begin
      step();
      n++;
      if (n == 1) begin
        ad_v[s] = ~a;
        wd_v[s] = ~d;
      end
      if (!ack_v[s]) chk("busy_wait", busy_v[s], 1'b1);
    end while (!ack_v[s] && n < 20);
    chk("latency", n - 1, lat);
    chk("ack", ack_v[s], 1'b1);
    chk("busy_at_ack", busy_v[s], 1'b0);
    chk("err", err_v[s], e);
    chk("rdata", rdata_v[s], exp_rd);
    for (int i = 0; i < hold; i++) begin
      step();
      chk("hold_ack", ack_v[s], 1'b1);
      chk("hold_busy", busy_v[s], 1'b0);
      chk("hold_rdata", rdata_v[s], exp_rd);
    end
    rd_v[s] = 1'b0;
    wr_v[s] = 1'b0;
    step();
    chk("drop_ack", ack_v[s], 1'b0);
    chk("drop_err", err_v[s], 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rd_v[i] = 1'b0; wr_v[i] = 1'b0; ad_v[i] = '0; wd_v[i] = '0;
    end
    #12;
    chk("rst_ack", ack_v[0], 1'b0);
    chk("rst_busy", busy_v[0], 1'b0);
    chk("rst_err", err_v[0], 1'b0);
    chk("rst_rdata", rdata_v[0], 16'h0);
    rst_n = 1'b1;
    step();

    // write then read back; write leaves rdata unchanged
    txn(0, 1'b0, 1'b1, 8'h05, 16'hBEEF, 3, 1'b0, 16'h0000, 0);
    txn(0, 1'b1, 1'b0, 8'h05, 16'h0000, 3, 1'b0, 16'hBEEF, 0);
    txn(0, 1'b0, 1'b1, 8'h10, 16'h5A5A, 3, 1'b0, 16'hBEEF, 0);
    // read+write conflict: err, rdata 0, no write
    txn(0, 1'b1, 1'b1, 8'h10, 16'h0000, 3, 1'b1, 16'h0000, 0);
    txn(0, 1'b1, 1'b0, 8'h10, 16'h0000, 3, 1'b0, 16'h5A5A, 0);
    // hold read past ack, then re-raise immediately after drop
    txn(0, 1'b1, 1'b0, 8'h05, 16'h0000, 3, 1'b0, 16'hBEEF, 5);
    txn(0, 1'b1, 1'b0, 8'h10, 16'h0000, 3, 1'b0, 16'h5A5A, 0);

    // reset in WAIT of a write must not commit it
    txn(0, 1'b0, 1'b1, 8'h07, 16'hAAAA, 3, 1'b0, 16'h5A5A, 0);
    wr_v[0] = 1'b1; ad_v[0] = 8'h07; wd_v[0] = 16'h1234;
    step();
    chk("rst_mid_busy_pre", busy_v[0], 1'b1);
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", busy_v[0], 1'b0);
    chk("rst_mid_ack", ack_v[0], 1'b0);
    chk("rst_mid_err", err_v[0], 1'b0);
    chk("rst_mid_rdata", rdata_v[0], 16'h0);
    wr_v[0] = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    txn(0, 1'b1, 1'b0, 8'h07, 16'h0000, 3, 1'b0, 16'hAAAA, 0);

    // DEPTH=200, zero wait: last valid word and first out-of-range address
    txn(1, 1'b0, 1'b1, 8'hC7, 16'h1111, 1, 1'b0, 16'h0000, 0);
    txn(1, 1'b1, 1'b0, 8'hC7, 16'h0000, 1, 1'b0, 16'h1111, 0);
    txn(1, 1'b1, 1'b0, 8'hC8, 16'h0000, 1, 1'b1, 16'h0000, 0);
    txn(1, 1'b0, 1'b1, 8'hFF, 16'h2222, 1, 1'b1, 16'h0000, 0);
    txn(1, 1'b1, 1'b0, 8'hC7, 16'h0000, 1, 1'b0, 16'h1111, 0);

`ifdef MEM_PARITY_EN
    txn(0, 1'b0, 1'b1, 8'h05, 16'hBEEF, 3, 1'b0, 16'hAAAA, 0);
    dut_a.u_arr.mem_q[5][0] = ~dut_a.u_arr.mem_q[5][0];
    txn(0, 1'b1, 1'b0, 8'h05, 16'h0000, 3, 1'b1, 16'hBEEE, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
